pe_col_drain: RTL and testbench
===============================

// Module: pe_col_drain
// PURPOSE
//  Drain stage directly downstream of the bottom PE row of the systolic array. Captures each
//  column's o_o (ACC_BW, Q(.2*FRA_BW)) arriving with systolic skew, deskews into aligned rows,
//  saturates/narrows each element to MUL_BW Q(INT_BW.FRA_BW), buffers rows in a FIFO, and
//  presents them with a valid/ready handshake to the writeback path.
// PARAMETERS
//  N_COL       4   number of PE columns (lanes)
//  INT_BW      5   integer bits of the narrow result (sign excluded)
//  FRA_BW      10  fraction bits of the narrow result; the accumulator carries 2*FRA_BW
//  MUL_BW      16  narrow result width (= 1+INT_BW+FRA_BW)
//  ACC_BW      32  accumulator width
//  FIFO_DEPTH  8   output row FIFO entries (power of 2, >= 2*N_COL)
// PORTS
//  clk        in   1              clock
//  rst_n      in   1              asynchronous reset, active low
//  clear_i    in   1              synchronous flush of pipeline, FIFO and flags
//  in_vld_i   in   N_COL          per-lane valid from bottom PE row; lane k is skewed k cycles after lane 0
//  in_dat_i   in   N_COL*ACC_BW   per-lane o_o; lane k in bits [k*ACC_BW +: ACC_BW]
//  out_vld_o  out  1              row available
//  out_rdy_i  in   1              consumer accepts row when out_vld_o & out_rdy_i
//  out_dat_o  out  N_COL*MUL_BW   narrowed row; lane k in bits [k*MUL_BW +: MUL_BW]
//  afull_o    out  1              free FIFO entries <= N_COL (array must stop issuing)
//  ovf_o      out  1              sticky: row dropped on a full FIFO
//  err_o      out  1              sticky: aligned valids not all equal (skew violation)
// BEHAVIOUR
//  - Reset/clear: delay lines, valids, FIFO pointers/count zero; out_vld_o=0, out_dat_o=0,
//    afull_o=0, ovf_o=0, err_o=0. Reset mid-row discards partial rows; no output follows.
//  - Deskew: lane k passes through N_COL-k registers (data+valid), so all lanes of row r
//    align one edge after lane N_COL-1 samples row r.
//  - Aligned valids all 1 -> row pushed at next edge. All 0 -> nothing. Mixed -> no push, err_o set.
//  - Narrowing per lane (signed): HI = 2^(INT_BW+2*FRA_BW)-1, LO = -2^(INT_BW+2*FRA_BW);
//    v > HI -> 0x7FFF (max pos); v < LO -> 0x8000 (max neg); else v[INT_BW+2*FRA_BW : FRA_BW].
//    Compare in ACC_BW+1 bits; no wrap ever.
//  - Latency: lane N_COL-1 sample at edge e -> aligned at e+1 -> FIFO write at e+2;
//    out_vld_o high from e+2 when FIFO was empty. Throughput one row/cycle.
//  - FIFO: out_dat_o = head entry (registered storage, combinational read); pop on vld&rdy.
//    Push+pop same cycle when full: both succeed, count unchanged.
//    Push when full and no pop: row dropped, ovf_o set.
//    Pop when empty: ignored. Pointers wrap modulo FIFO_DEPTH.
//  - afull_o combinational from count; covers the N_COL-1 rows still in the delay lines.
//  - ovf_o/err_o cleared only by rst_n or clear_i. clear_i wins over a same-cycle push/pop.
// CONFIGURATION
//  PE_DRAIN_ROUND_EN defined: add 2^(FRA_BW-1) (round half up) before saturation check and
//    slice. Sum formed in ACC_BW+1 bits so overflow from rounding saturates to 0x7FFF.
//  Undefined: plain truncation (floor). Latency identical in both builds.
// STRUCTURE
//  - Package raven_pe_pkg: INT_BW/FRA_BW/MUL_BW/ACC_BW defaults, sat_max/sat_min constants,
//    function sat_narrow(acc) -> mul (honours PE_DRAIN_ROUND_EN), typedef row_t.
//  - One sub-module: pe_drain_fifo (sync FIFO, WIDTH=N_COL*MUL_BW, DEPTH=FIFO_DEPTH,
//    count output). Deskew and narrowing stay in pe_col_drain.
// TESTING (N_COL=4, defaults)
//  1 Skewed row: lane k data 0x0010_0000 valid at cycle k -> one row of 4x0x0400;
//    out_vld_o at cycle 5.
//  2 Saturation: lanes 0x7FFF_FFFF, 0x8000_0000, 0x01FF_FFFF, 0xFE00_0000
//    -> 0x7FFF, 0x8000, 0x7FFF, 0x8000.
//  3 Rounding: lane 0x0000_0200 -> 0x0001 with PE_DRAIN_ROUND_EN, 0x0000 without;
//    0x01FF_FE00 -> 0x7FFF both.
//  4 Backpressure: out_rdy_i=0, stream 9 rows -> afull_o at count>=4, 8 rows kept,
//    row 9 dropped, ovf_o=1; then rdy=1 drains 8 rows in order.
//  5 Full push+pop: FIFO full, push and pop same cycle -> count stays 8, ovf_o stays 0.
//  6 Skew error / reset: lane 2 valid one cycle late -> err_o=1, no row;
//    rst_n low mid-stream -> all outputs 0 next sample.

Source files
------------

// File: rtl/pe_col_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : raven_pe_pkg
//  Description : Shared widths, saturation limits and the accumulator-to-
//                narrow conversion used by the systolic drain stage.
//                Optional rounding: define PE_DRAIN_ROUND_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package raven_pe_pkg;

  localparam int N_COL_DEF = 4;
  localparam int INT_BW    = 5;
  localparam int FRA_BW    = 10;
  localparam int MUL_BW    = 1 + INT_BW + FRA_BW;
  localparam int ACC_BW    = 32;

  // Top bit of the accumulator slice that survives narrowing.
  localparam int NARROW_MSB = INT_BW + 2 * FRA_BW;

  localparam logic [MUL_BW-1:0] SAT_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic [MUL_BW-1:0] SAT_MIN = {1'b1, {(MUL_BW-1){1'b0}}};

  // Representable range of the narrow result, expressed in accumulator units
  // with one guard bit so rounding can never wrap.
  localparam logic signed [ACC_BW:0] ACC_HI =
    {{(ACC_BW+1-NARROW_MSB){1'b0}}, {NARROW_MSB{1'b1}}};
  localparam logic signed [ACC_BW:0] ACC_LO =
    {{(ACC_BW+1-NARROW_MSB){1'b1}}, {NARROW_MSB{1'b0}}};

`ifdef PE_DRAIN_ROUND_EN
  // Half of one narrow LSB: round half up.
  localparam logic signed [ACC_BW:0] ROUND_INC =
    {{(ACC_BW+1-FRA_BW){1'b0}}, 1'b1, {(FRA_BW-1){1'b0}}};
`endif

  typedef logic [N_COL_DEF*MUL_BW-1:0] row_t;

  // Saturating signed narrow from Q(.2*FRA_BW) accumulator to Q(INT_BW.FRA_BW).
  function automatic logic [MUL_BW-1:0] sat_narrow(input logic [ACC_BW-1:0] acc);
    logic signed [ACC_BW:0] v;
    v = $signed({acc[ACC_BW-1], acc});
`ifdef PE_DRAIN_ROUND_EN
    v = v + ROUND_INC;
`endif
    if (v > ACC_HI) begin
      return SAT_MAX;
    end else if (v < ACC_LO) begin
      return SAT_MIN;
    end else begin
      return v[NARROW_MSB:FRA_BW];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_col_drain_if.sv
`default_nettype none
// ============================================================================
//  Module      : pe_col_drain_if
//  Description : Row output handshake of the drain stage (valid/ready + row).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pe_col_drain_if #(
  parameter int N_COL  = 4,
  parameter int MUL_BW = 16
) ();
  logic                    out_vld_o;
  logic                    out_rdy_i;
  logic [N_COL*MUL_BW-1:0] out_dat_o;

  // Producer side (the drain stage).
  modport master (
    output out_vld_o,
    output out_dat_o,
    input  out_rdy_i
  );

  // Consumer side (writeback path).
  modport slave (
    input  out_vld_o,
    input  out_dat_o,
    output out_rdy_i
  );
endinterface
`default_nettype wire

// File: rtl/pe_drain_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pe_drain_fifo
//  Description : Synchronous row FIFO with combinational head read, occupancy
//                count and push-through-when-full if a pop happens the same
//                cycle. Synchronous clear overrides push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_drain_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_dat_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       vld_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q,  count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign vld_o   = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop on an empty FIFO is ignored; a push on a full FIFO only lands when
  // the same cycle frees the head slot.
  assign do_pop  = pop_i & vld_o & ~clear_i;
  assign do_push = push_i & (~full_o | do_pop) & ~clear_i;

  // Next-state for pointers, count and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat_i;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Row storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/pe_col_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pe_col_drain
//  Description : Drain stage under the bottom PE row. Deskews the per-column
//                accumulator outputs, saturates each to MUL_BW, buffers whole
//                rows in a FIFO and offers them on a valid/ready interface.
//                Build option PE_DRAIN_ROUND_EN: round half up before narrowing
//                (default: truncate). Latency is the same in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_col_drain
  import raven_pe_pkg::*;
#(
  parameter int N_COL      = N_COL_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic [N_COL-1:0]          in_vld_i,
  input  logic [N_COL*ACC_BW-1:0]   in_dat_i,
  pe_col_drain_if.master            out_if,
  output logic                      afull_o,
  output logic                      ovf_o,
  output logic                      err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Rows still in flight in the delay lines must always find a free slot.
  localparam logic [CW-1:0] AFULL_CNT = CW'(FIFO_DEPTH - N_COL);

  logic [N_COL-1:0]        tail_vld;
  logic [ACC_BW-1:0]       tail_dat [N_COL];

  logic [N_COL-1:0]        aln_vld_q, aln_vld_d;
  logic [N_COL*MUL_BW-1:0] aln_dat_q, aln_dat_d;

  logic ovf_q, ovf_d;
  logic err_q, err_d;

  logic                    row_push;
  logic                    row_mixed;
  logic                    row_pop;
  logic [N_COL*MUL_BW-1:0] fifo_head;
  logic                    fifo_vld;
  logic                    fifo_full;
  logic [CW-1:0]           fifo_count;

  // --------------------------------------------------------------------------
  // Deskew: lane k sees N_COL-k stages so every lane of a row reaches its
  // tail on the same edge that the last lane enters its only stage.
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_COL; k++) begin : g_lane
    localparam int STAGES = N_COL - k;

    logic [STAGES-1:0] vld_q, vld_d;
    logic [ACC_BW-1:0] dat_q [STAGES];
    logic [ACC_BW-1:0] dat_d [STAGES];

    // Shift the lane's delay line; clear empties it.
    always_comb begin
      vld_d = '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_d[s] = '0;
      end
      if (!clear_i) begin
        vld_d[0] = in_vld_i[k];
        dat_d[0] = in_dat_i[k*ACC_BW +: ACC_BW];
        for (int s = 1; s < STAGES; s++) begin
          vld_d[s] = vld_q[s-1];
          dat_d[s] = dat_q[s-1];
        end
      end
    end

    // Delay line registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int s = 0; s < STAGES; s++) begin
          dat_q[s] <= '0;
        end
      end else begin
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end

    assign tail_vld[k] = vld_q[STAGES-1];
    assign tail_dat[k] = dat_q[STAGES-1];
  end

  // Aligned stage input: narrow every lane of the deskewed row.
  always_comb begin
    aln_vld_d = '0;
    aln_dat_d = '0;
    if (!clear_i) begin
      aln_vld_d = tail_vld;
      for (int k = 0; k < N_COL; k++) begin
        aln_dat_d[k*MUL_BW +: MUL_BW] = sat_narrow(tail_dat[k]);
      end
    end
  end

  // A complete row pushes; a partial row is a skew violation and is dropped.
  assign row_push  = &aln_vld_q;
  assign row_mixed = (|aln_vld_q) & ~(&aln_vld_q);
  assign row_pop   = out_if.out_vld_o & out_if.out_rdy_i;

  // Sticky flags, cleared only by reset or clear.
  always_comb begin
    ovf_d = ovf_q;
    err_d = err_q;
    if (clear_i) begin
      ovf_d = 1'b0;
      err_d = 1'b0;
    end else begin
      if (row_push & fifo_full & ~row_pop) begin
        ovf_d = 1'b1;
      end
      if (row_mixed) begin
        err_d = 1'b1;
      end
    end
  end

  // Aligned row register and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aln_vld_q <= '0;
      aln_dat_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      aln_vld_q <= aln_vld_d;
      aln_dat_q <= aln_dat_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  pe_drain_fifo #(
    .WIDTH (N_COL*MUL_BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear_i),
    .push_i     (row_push),
    .push_dat_i (aln_dat_q),
    .pop_i      (row_pop),
    .head_o     (fifo_head),
    .vld_o      (fifo_vld),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  // Output data is forced to zero while nothing is offered.
  assign out_if.out_vld_o = fifo_vld;
  assign out_if.out_dat_o = fifo_vld ? fifo_head : '0;
  assign afull_o          = (fifo_count >= AFULL_CNT);
  assign ovf_o            = ovf_q;
  assign err_o            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_col_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_col_drain
//  Description : Self-checking bench for pe_col_drain (N_COL=4, defaults).
//                Table of single-row narrowing vectors plus hand-written
//                backpressure, full push+pop, skew-error and reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_col_drain;
  import raven_pe_pkg::*;

  localparam int NC = 4;
  localparam int AB = 32;
  localparam int MB = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear_i = 1'b0;
  logic [NC-1:0]     in_vld_i = '0;
  logic [NC*AB-1:0]  in_dat_i = '0;
  logic              afull_o, ovf_o, err_o;

  pe_col_drain_if #(.N_COL(NC), .MUL_BW(MB)) out_if ();

  pe_col_drain #(.N_COL(NC), .FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (clear_i),
    .in_vld_i (in_vld_i),
    .in_dat_i (in_dat_i),
    .out_if   (out_if),
    .afull_o  (afull_o),
    .ovf_o    (ovf_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [NC-1:0][AB-1:0] lane;
    logic [NC-1:0][MB-1:0] exp;
  } vec_t;

  vec_t        vecs [4];
  logic [AB-1:0] s_dat [16][NC];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nrows back-to-back rows with lane k skewed k cycles; late_lane is
  // additionally delayed by late_by cycles.
  task automatic stream(input int nrows, input int late_lane, input int late_by);
    int ncyc;
    ncyc = nrows + NC - 1 + late_by;
    for (int c = 0; c < ncyc; c++) begin
      in_vld_i = '0;
      in_dat_i = '0;
      for (int k = 0; k < NC; k++) begin
        int r;
        r = c - k - ((k == late_lane) ? late_by : 0);
        if (r >= 0 && r < nrows) begin
          in_vld_i[k]           = 1'b1;
          in_dat_i[k*AB +: AB]  = s_dat[r][k];
        end
      end
      tick();
    end
    in_vld_i = '0;
    in_dat_i = '0;
  endtask

  // Row idx: lane k = (idx+1)<<20 + k<<16, narrows to (idx+1)*1024 + k*64.
  task automatic set_row(input int slot, input int idx);
    for (int k = 0; k < NC; k++) begin
      s_dat[slot][k] = AB'(((idx + 1) << 20) + (k << 16));
    end
  endtask

  function automatic logic [NC*MB-1:0] exp_row(input int idx);
    logic [NC*MB-1:0] r;
    for (int k = 0; k < NC; k++) begin
      r[k*MB +: MB] = MB'((idx + 1) * 1024 + k * 64);
    end
    return r;
  endfunction

  task automatic pulse_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  initial begin
    // ---------------- vector table ----------------
    vecs[0].lane = {32'h0010_0000, 32'h0010_0000, 32'h0010_0000, 32'h0010_0000};
    vecs[0].exp  = {16'h0400, 16'h0400, 16'h0400, 16'h0400};
    vecs[1].lane = {32'hFE00_0000, 32'h01FF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    vecs[1].exp  = {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    vecs[2].lane = {32'hFFFF_FE00, 32'hFFFF_FC00, 32'h01FF_FE00, 32'h0000_0200};
`ifdef PE_DRAIN_ROUND_EN
    vecs[2].exp  = {16'h0000, 16'hFFFF, 16'h7FFF, 16'h0001};
`else
    vecs[2].exp  = {16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0000};
`endif
    vecs[3].lane = {32'h1234_5678, 32'h0000_0400, 32'h0200_0000, 32'hFDFF_FFFF};
    vecs[3].exp  = {16'h7FFF, 16'h0001, 16'h7FFF, 16'h8000};

    out_if.out_rdy_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset_vld",   64'(out_if.out_vld_o), 64'd0);
    check("reset_dat",   64'(out_if.out_dat_o), 64'd0);
    check("reset_afull", 64'(afull_o), 64'd0);
    check("reset_ovf",   64'(ovf_o),   64'd0);
    check("reset_err",   64'(err_o),   64'd0);
    rst_n = 1'b1;
    tick();

    // Lane 0 sampled at edge 0 -> row visible after edge 5.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NC; k++) s_dat[0][k] = vecs[i].lane[k];
      stream(1, -1, 0);
      tick();
      check($sformatf("vec%0d_vld_e4", i), 64'(out_if.out_vld_o), 64'd0);
      tick();
      check($sformatf("vec%0d_vld_e5", i), 64'(out_if.out_vld_o), 64'd1);
      for (int k = 0; k < NC; k++) begin
        check($sformatf("vec%0d_lane%0d", i, k),
              64'(out_if.out_dat_o[k*MB +: MB]), 64'(vecs[i].exp[k]));
      end
      out_if.out_rdy_i = 1'b1;
      tick();
      out_if.out_rdy_i = 1'b0;
      check($sformatf("vec%0d_popped", i), 64'(out_if.out_vld_o), 64'd0);
    end
    check("vec_err_clean", 64'(err_o), 64'd0);

    // ---------------- backpressure ----------------
    for (int r = 0; r < 9; r++) set_row(r, r);
    stream(3, -1, 0);
    tick(); tick();
    check("bp_afull_cnt3", 64'(afull_o), 64'd0);
    for (int k = 0; k < NC; k++) s_dat[0][k] = s_dat[3][k];
    stream(1, -1, 0);
    tick(); tick();
    check("bp_afull_cnt4", 64'(afull_o), 64'd1);
    for (int r = 0; r < 4; r++) set_row(r, r + 4);
    stream(4, -1, 0);
    tick(); tick();
    check("bp_ovf_at8", 64'(ovf_o), 64'd0);
    set_row(0, 8);
    stream(1, -1, 0);
    tick(); tick();
    check("bp_ovf_row9", 64'(ovf_o), 64'd1);
    out_if.out_rdy_i = 1'b1;
    for (int r = 0; r < 8; r++) begin
      check($sformatf("bp_drain%0d_vld", r), 64'(out_if.out_vld_o), 64'd1);
      check($sformatf("bp_drain%0d_dat", r), 64'(out_if.out_dat_o), 64'(exp_row(r)));
      tick();
    end
    out_if.out_rdy_i = 1'b0;
    check("bp_empty", 64'(out_if.out_vld_o), 64'd0);
    check("bp_ovf_sticky", 64'(ovf_o), 64'd1);
    pulse_clear();
    check("bp_ovf_cleared", 64'(ovf_o), 64'd0);

    // ---------------- full push + pop ----------------
    for (int r = 0; r < 8; r++) set_row(r, r);
    stream(8, -1, 0);
    tick(); tick();
    check("fpp_full_afull", 64'(afull_o), 64'd1);
    set_row(0, 20);
    stream(1, -1, 0);
    tick();
    out_if.out_rdy_i = 1'b1;
    tick();
    out_if.out_rdy_i = 1'b0;
    check("fpp_ovf", 64'(ovf_o), 64'd0);
    out_if.out_rdy_i = 1'b1;
    for (int r = 0; r < 8; r++) begin
      int idx;
      idx = (r < 7) ? r + 1 : 20;
      check($sformatf("fpp_drain%0d_vld", r), 64'(out_if.out_vld_o), 64'd1);
      check($sformatf("fpp_drain%0d_dat", r), 64'(out_if.out_dat_o), 64'(exp_row(idx)));
      tick();
    end
    out_if.out_rdy_i = 1'b0;
    check("fpp_empty", 64'(out_if.out_vld_o), 64'd0);

    // ---------------- skew error ----------------
    set_row(0, 2);
    stream(1, 2, 1);
    repeat (4) tick();
    check("skew_err", 64'(err_o), 64'd1);
    check("skew_no_row", 64'(out_if.out_vld_o), 64'd0);

    // ---------------- reset mid-row ----------------
    in_vld_i = 4'b0001;
    in_dat_i[0 +: AB] = 32'h0010_0000;
    tick();
    in_vld_i = 4'b0010;
    in_dat_i = '0;
    in_dat_i[AB +: AB] = 32'h0010_0000;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_vld",   64'(out_if.out_vld_o), 64'd0);
    check("rst_dat",   64'(out_if.out_dat_o), 64'd0);
    check("rst_afull", 64'(afull_o), 64'd0);
    check("rst_ovf",   64'(ovf_o),   64'd0);
    check("rst_err",   64'(err_o),   64'd0);
    in_vld_i = '0;
    in_dat_i = '0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("rst_no_row", 64'(out_if.out_vld_o), 64'd0);

    // ---------------- clear drops the error flag ----------------
    stream(1, 1, 1);
    repeat (4) tick();
    check("clr_err_set", 64'(err_o), 64'd1);
    pulse_clear();
    check("clr_err_cleared", 64'(err_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
